// File: rtl/uart_pkg.sv
// Shared UART types and constants for the receive path and any future transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_e;

  localparam int   DATA_BITS = 8;
  localparam logic UART_IDLE = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Generic first-word-fall-through FIFO: head readable combinationally, a push is visible the next cycle.
// A push while full is dropped unless a pop happens in the same cycle; a pop while empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           wr_en_i,
  input  logic [WIDTH-1:0]               wr_data_i,
  input  logic                           rd_en_i,
  output logic [WIDTH-1:0]               rd_data_o,
  output logic                           empty_o,
  output logic                           full_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_wr, do_rd;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CW'(DEPTH));
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_rd = rd_en_i && !empty_o;
  assign do_wr = wr_en_i && (!full_o || rd_en_i);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_wr && !do_rd) count_d = count_q + 1'b1;
    if (do_rd && !do_wr) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with oversampling deframer feeding a FWFT byte FIFO; byte visible one cycle after stop sample.
// No backpressure on the line: a byte completing into a full FIFO without a pop is dropped and flags overrun.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              ena,
  input  logic                              rx,
  input  logic                              rd_en,
  output logic [7:0]                        rd_data,
  output logic                              empty,
  output logic                              full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
  output logic                              frame_err,
  output logic                              overrun,
  input  logic                              err_clr
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  rx_state_e              state_q;
  logic [TW-1:0]          timer_q;
  logic [2:0]             bit_idx_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   frame_err_q, overrun_q;
  logic                   stop_hit, push, ferr_set, ovr_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end

  assign rxs = sync_q[SYNC_STAGES-1];

  // Stop-bit decision is taken straight from state so the push lands on the sampling edge.
  assign stop_hit = ena && (state_q == STOP) && (timer_q == BIT_LAST);
  assign push     = stop_hit && (rxs == UART_IDLE);
  assign ferr_set = stop_hit && (rxs != UART_IDLE);
  assign ovr_set  = push && full && !rd_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else if (!ena) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          timer_q   <= '0;
          bit_idx_q <= '0;
          if (rxs != UART_IDLE) state_q <= START;
        end
        START: begin
          if (timer_q == HALF_LAST) begin
            timer_q <= '0;
            state_q <= (rxs == UART_IDLE) ? IDLE : DATA;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        DATA: begin
          if (timer_q == BIT_LAST) begin
            timer_q   <= '0;
            shift_q   <= {rxs, shift_q[DATA_BITS-1:1]};
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == 3'(DATA_BITS - 1)) state_q <= STOP;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        STOP: begin
          if (timer_q == BIT_LAST) begin
            timer_q <= '0;
            state_q <= (rxs == UART_IDLE) ? IDLE : WAIT_IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (rxs == UART_IDLE) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Set events take priority over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (ferr_set)     frame_err_q <= 1'b1;
      else if (err_clr) frame_err_q <= 1'b0;
      if (ovr_set)      overrun_q   <= 1'b1;
      else if (err_clr) overrun_q   <= 1'b0;
    end
  end

  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .wr_en_i   (push),
    .wr_data_i (shift_q),
    .rd_en_i   (rd_en),
    .rd_data_o (rd_data),
    .empty_o   (empty),
    .full_o    (full),
    .count_o   (count)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo with CLKS_PER_BIT=8, FIFO_DEPTH=4: directed table, corner sequences, random frames vs a queue model.
module tb_uart_rx_fifo;

  localparam int CPB = 8;
  localparam int DEP = 4;

  logic       clk, rst_n, ena, rx, rd_en, err_clr;
  logic [7:0] rd_data;
  logic       empty, full, frame_err, overrun;
  logic [2:0] count;

  int total = 0;
  int bad   = 0;

  logic [7:0] mq[$];
  bit         m_ferr, m_ovr;

  typedef struct {
    bit         is_pop;
    logic [7:0] dat;
    bit         e_empty;
    bit         e_full;
    int         e_count;
    logic [7:0] e_head;
    bit         e_ovr;
  } vec_t;

  vec_t tbl[9];

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEP), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .rx        (rx),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .frame_err (frame_err),
    .overrun   (overrun),
    .err_clr   (err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pop_one();
    @(posedge clk); #1 rd_en = 1'b1;
    @(posedge clk); #1 rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
  endtask

  // Start bit driven just after edge P0; the stop bit is sampled on edge P79.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input int hold,
                            input bit pop_on_push, input bit chk_timing, input int ena_off_bit);
    @(posedge clk); #1 rx = 1'b0;
    for (int k = 0; k < 8; k++) begin
      repeat (CPB) @(posedge clk);
      #1 rx = d[k];
      if (k == ena_off_bit) ena = 1'b0;
    end
    repeat (CPB) @(posedge clk);
    #1 rx = stop_b;
    repeat (6) @(posedge clk);
    #1;
    if (pop_on_push) rd_en = 1'b1;
    if (chk_timing) begin
      @(negedge clk);
      chk("pre_push_empty", empty, 1);
    end
    @(posedge clk); #1 rd_en = 1'b0;
    if (chk_timing) begin
      @(negedge clk);
      chk("push_empty", empty, 0);
      chk("push_count", count, 1);
      chk("push_data", rd_data, d);
    end
    if (!stop_b) begin
      repeat (hold) @(posedge clk);
      #1 rx = 1'b1;
    end
    repeat (5) @(posedge clk);
    #1 ena = 1'b1;
  endtask

  task automatic check_model(input string nm);
    @(negedge clk);
    chk({nm, "_count"}, count, mq.size());
    chk({nm, "_empty"}, empty, mq.size() == 0);
    chk({nm, "_full"},  full,  mq.size() == DEP);
    chk({nm, "_ferr"},  frame_err, m_ferr);
    chk({nm, "_ovr"},   overrun,   m_ovr);
    if (mq.size() > 0) chk({nm, "_head"}, rd_data, mq[0]);
  endtask

  initial begin
    logic [7:0] t5 [4];
    logic [7:0] d;
    logic       stop_b;
    int         npop;

    rst_n = 1'b0; ena = 1'b1; rx = 1'b1; rd_en = 1'b0; err_clr = 1'b0;

    tbl[0] = '{0, 8'h01, 0, 0, 1, 8'h01, 0};
    tbl[1] = '{0, 8'h02, 0, 0, 2, 8'h01, 0};
    tbl[2] = '{0, 8'h03, 0, 0, 3, 8'h01, 0};
    tbl[3] = '{0, 8'h04, 0, 1, 4, 8'h01, 0};
    tbl[4] = '{0, 8'h05, 0, 1, 4, 8'h01, 1};
    tbl[5] = '{1, 8'h00, 0, 0, 3, 8'h02, 1};
    tbl[6] = '{1, 8'h00, 0, 0, 2, 8'h03, 1};
    tbl[7] = '{1, 8'h00, 0, 0, 1, 8'h04, 1};
    tbl[8] = '{1, 8'h00, 1, 0, 0, 8'h00, 1};
    t5[0] = 8'h11; t5[1] = 8'h12; t5[2] = 8'h13; t5[3] = 8'h77;

    do_reset();
    @(negedge clk);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_data", rd_data, 8'h00);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);

    // Clean byte with exact push timing, then drain.
    send_frame(8'hA5, 1'b1, 0, 0, 1, -1);
    pop_one();
    @(negedge clk);
    chk("t1_pop_empty", empty, 1);
    chk("t1_pop_count", count, 0);

    // Short low glitch must not start a frame.
    @(posedge clk); #1 rx = 1'b0;
    repeat (2) @(posedge clk);
    #1 rx = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("t2_glitch_empty", empty, 1);
    chk("t2_glitch_ferr", frame_err, 0);
    send_frame(8'h3C, 1'b1, 0, 0, 0, -1);
    @(negedge clk);
    chk("t2_count", count, 1);
    chk("t2_data", rd_data, 8'h3C);
    pop_one();

    // Bad stop bit followed by a long break; a clear on the error edge loses to the set.
    fork
      send_frame(8'h3C, 1'b0, 40, 0, 0, -1);
      begin
        repeat (79) @(posedge clk);
        #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        @(negedge clk);
        chk("t3_set_wins", frame_err, 1);
        chk("t3_no_push", empty, 1);
        repeat (10) @(posedge clk);
        #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        @(negedge clk);
        chk("t3_cleared", frame_err, 0);
      end
    join
    @(negedge clk);
    chk("t3_single_event", frame_err, 0);
    chk("t3_empty", empty, 1);

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].is_pop) pop_one();
      else send_frame(tbl[i].dat, 1'b1, 0, 0, 0, -1);
      @(negedge clk);
      chk($sformatf("t4_%0d_count", i), count, tbl[i].e_count);
      chk($sformatf("t4_%0d_empty", i), empty, tbl[i].e_empty);
      chk($sformatf("t4_%0d_full", i), full, tbl[i].e_full);
      chk($sformatf("t4_%0d_ovr", i), overrun, tbl[i].e_ovr);
      if (!tbl[i].e_empty) chk($sformatf("t4_%0d_head", i), rd_data, tbl[i].e_head);
    end
    pop_one();
    @(negedge clk);
    chk("t4_underflow_count", count, 0);
    pulse_clr();
    @(negedge clk);
    chk("t4_ovr_clr", overrun, 0);

    // Push into a full FIFO with a simultaneous pop.
    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1, 0, 0, 0, -1);
    @(negedge clk);
    chk("t5_full", full, 1);
    send_frame(8'h77, 1'b1, 0, 1, 0, -1);
    @(negedge clk);
    chk("t5_count", count, 4);
    chk("t5_ovr", overrun, 0);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk($sformatf("t5_pop%0d", j), rd_data, t5[j]);
      pop_one();
    end
    @(negedge clk);
    chk("t5_empty", empty, 1);

    // Reset in the middle of a frame.
    @(posedge clk); #1 rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1 rx = 1'b1;
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_empty", empty, 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (90) @(posedge clk);
    @(negedge clk);
    chk("t6_no_residue", count, 0);
    send_frame(8'h12, 1'b1, 0, 0, 0, -1);
    @(negedge clk);
    chk("t6_count", count, 1);
    chk("t6_data", rd_data, 8'h12);
    pop_one();

    // Enable dropped mid-frame.
    send_frame(8'h5A, 1'b1, 0, 0, 0, 3);
    @(negedge clk);
    chk("t6_ena_empty", empty, 1);
    chk("t6_ena_ferr", frame_err, 0);

    // Random frames against the queue model.
    do_reset();
    mq.delete();
    m_ferr = 0;
    m_ovr  = 0;
    for (int it = 0; it < 24; it++) begin
      d      = 8'($urandom_range(0, 255));
      stop_b = ($urandom_range(0, 5) != 0);
      send_frame(d, stop_b, $urandom_range(4, 30), 0, 0, -1);
      if (!stop_b) m_ferr = 1;
      else if (mq.size() < DEP) mq.push_back(d);
      else m_ovr = 1;
      check_model("rnd_frame");
      npop = $urandom_range(0, 2);
      for (int p = 0; p < npop; p++) begin
        pop_one();
        if (mq.size() > 0) void'(mq.pop_front());
      end
      if ($urandom_range(0, 3) == 0) begin
        pulse_clr();
        m_ferr = 0;
        m_ovr  = 0;
      end
      check_model("rnd_drain");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
